// File: rtl/dda_pkg.sv
// Shared types and helpers for the sequential double-dabble BCD converter.
package dda_pkg;

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} dda_state_t;

    localparam int BCD_NIB = 4;

    function automatic logic [3:0] add3_nib(input logic [3:0] d);
        return (d > 4'd4) ? d + 4'd3 : d;
    endfunction

    // Elaboration-time helper for the digit-capacity check.
    function automatic longint unsigned pow10(input int n);
        longint unsigned r;
        r = 64'd1;
        for (int i = 0; i < n; i++) r = r * 64'd10;
        return r;
    endfunction

endpackage

// File: rtl/dda_add3_stage.sv
// One double-dabble iteration: add-3 on every BCD nibble above 4, then shift the
// whole {bcd, bin} register left by one.
module dda_add3_stage
    import dda_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic [BIN_W+BCD_NIB*DIGITS-1:0] sr_in,
    output logic [BIN_W+BCD_NIB*DIGITS-1:0] sr_out
);

    localparam int BCD_W = BCD_NIB * DIGITS;
    localparam int SR_W  = BIN_W + BCD_W;

    logic [BCD_W-1:0] bcd_adj;
    logic [SR_W-1:0]  pre_shift;

    for (genvar i = 0; i < DIGITS; i++) begin : g_nib
        assign bcd_adj[i*BCD_NIB +: BCD_NIB] = add3_nib(sr_in[BIN_W + i*BCD_NIB +: BCD_NIB]);
    end

    assign pre_shift = {bcd_adj, sr_in[BIN_W-1:0]};
    assign sr_out    = pre_shift << 1;

endmodule

// File: rtl/dda_seq_ctrl.sv
// Sequential binary-to-BCD controller, one double-dabble iteration per clock.
// Optional DDA_DIGIT_COUNT_EN adds out_ndig (count of significant decimal digits).
module dda_seq_ctrl
    import dda_pkg::*;
#(
    parameter int BIN_W  = 8,
    parameter int DIGITS = 3
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic [BIN_W-1:0]            in_bin,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic [BCD_NIB*DIGITS-1:0]   out_bcd,
`ifdef DDA_DIGIT_COUNT_EN
    output logic [$clog2(DIGITS+1)-1:0] out_ndig,
`endif
    output logic                        busy
);

    localparam int BCD_W = BCD_NIB * DIGITS;
    localparam int SR_W  = BIN_W + BCD_W;
    localparam int CNT_W = $clog2(BIN_W + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIN_W - 1);

    if (BIN_W < 4 || BIN_W > 32) begin : g_bad_width
        $error("dda_seq_ctrl: BIN_W=%0d outside 4..32", BIN_W);
    end
    if (pow10(DIGITS) <= ((64'd1 << BIN_W) - 64'd1)) begin : g_bad_digits
        $error("dda_seq_ctrl: DIGITS=%0d too small for BIN_W=%0d", DIGITS, BIN_W);
    end

    dda_state_t       state_q, state_d;
    logic [SR_W-1:0]  sr_q, sr_next;
    logic [CNT_W-1:0] cnt_q;
    logic             last_iter;
    logic [BCD_W-1:0] bcd_next;

    dda_add3_stage #(.BIN_W(BIN_W), .DIGITS(DIGITS)) u_stage (
        .sr_in  (sr_q),
        .sr_out (sr_next)
    );

    assign last_iter = (state_q == SHIFT) && (cnt_q == CNT_LAST);
    assign bcd_next  = sr_next[SR_W-1 -: BCD_W];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= IDLE;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (in_valid)  state_d = SHIFT;
            SHIFT:   if (last_iter) state_d = DONE;
            DONE:    if (out_ready) state_d = IDLE;
            default:                state_d = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state_q == IDLE);
        out_valid = (state_q == DONE);
        busy      = (state_q == SHIFT) || (state_q == DONE);
    end

    // out_bcd is loaded only on the SHIFT->DONE edge, so it holds across IDLE.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sr_q    <= '0;
            cnt_q   <= '0;
            out_bcd <= '0;
        end else begin
            if (state_q == IDLE && in_valid) begin
                sr_q  <= SR_W'(in_bin);
                cnt_q <= '0;
            end else if (state_q == SHIFT) begin
                sr_q  <= sr_next;
                cnt_q <= cnt_q + 1'b1;
            end
            if (last_iter) out_bcd <= bcd_next;
        end
    end

`ifdef DDA_DIGIT_COUNT_EN
    localparam int NDIG_W = $clog2(DIGITS + 1);
    logic [NDIG_W-1:0] ndig_next;

    always_comb begin
        ndig_next = NDIG_W'(1);
        for (int i = 0; i < DIGITS; i++) begin
            if (bcd_next[i*BCD_NIB +: BCD_NIB] != '0) ndig_next = NDIG_W'(i + 1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)         out_ndig <= '0;
        else if (last_iter) out_ndig <= ndig_next;
    end
`endif

endmodule

// File: tb/tb_dda_seq_ctrl.sv
// Directed + randomized bench for dda_seq_ctrl (8-bit/3-digit and 16-bit/5-digit builds).
module tb_dda_seq_ctrl;

    logic        clk, rst_n;

    logic        in_valid_a, in_ready_a, out_valid_a, out_ready_a, busy_a;
    logic [7:0]  in_bin_a;
    logic [11:0] out_bcd_a;

    logic        in_valid_b, in_ready_b, out_valid_b, out_ready_b, busy_b;
    logic [15:0] in_bin_b;
    logic [19:0] out_bcd_b;

`ifdef DDA_DIGIT_COUNT_EN
    logic [1:0]  out_ndig_a;
    logic [2:0]  out_ndig_b;
`endif

    int n_cmp = 0;
    int n_mis = 0;

    dda_seq_ctrl #(.BIN_W(8), .DIGITS(3)) u_dut_a (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_a),
        .in_ready  (in_ready_a),
        .in_bin    (in_bin_a),
        .out_valid (out_valid_a),
        .out_ready (out_ready_a),
        .out_bcd   (out_bcd_a),
`ifdef DDA_DIGIT_COUNT_EN
        .out_ndig  (out_ndig_a),
`endif
        .busy      (busy_a)
    );

    dda_seq_ctrl #(.BIN_W(16), .DIGITS(5)) u_dut_b (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid_b),
        .in_ready  (in_ready_b),
        .in_bin    (in_bin_b),
        .out_valid (out_valid_b),
        .out_ready (out_ready_b),
        .out_bcd   (out_bcd_b),
`ifdef DDA_DIGIT_COUNT_EN
        .out_ndig  (out_ndig_b),
`endif
        .busy      (busy_b)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference: decimal digits by repeated division, packed one per nibble.
    function automatic logic [63:0] to_bcd(input longint unsigned v);
        logic [63:0] r;
        r = '0;
        for (int i = 0; i < 16; i++) begin
            r[4*i +: 4] = 4'(v % 64'd10);
            v = v / 64'd10;
        end
        return r;
    endfunction

    function automatic int num_digits(input longint unsigned v);
        int n;
        n = 1;
        v = v / 64'd10;
        while (v != 0) begin
            n++;
            v = v / 64'd10;
        end
        return n;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction on the 8-bit instance; noise keeps in_valid high with
    // a different operand from the accept until the result is released.
    task automatic conv_a(input logic [7:0] v, input int hold, input bit noise);
        logic [63:0] exp_bcd;
        int          k;
        bit          busy_ok;
        exp_bcd = to_bcd(64'(v));
        chk("a_in_ready_before", 64'(in_ready_a), 64'd1);
        in_bin_a   = v;
        in_valid_a = 1'b1;
        tick();
        if (noise) in_bin_a = 8'd7;
        else       in_valid_a = 1'b0;
        k       = 0;
        busy_ok = 1'b1;
        while (!out_valid_a && k < 100) begin
            if (!busy_a || in_ready_a) busy_ok = 1'b0;
            tick();
            k++;
        end
        chk("a_latency", 64'(k), 64'd8);
        chk("a_busy_shift", 64'(busy_ok), 64'd1);
        chk("a_bcd", 64'(out_bcd_a), exp_bcd);
`ifdef DDA_DIGIT_COUNT_EN
        chk("a_ndig", 64'(out_ndig_a), 64'(num_digits(64'(v))));
`endif
        for (int h = 0; h < hold; h++) begin
            tick();
            chk("a_hold_valid", 64'(out_valid_a), 64'd1);
            chk("a_hold_bcd", 64'(out_bcd_a), exp_bcd);
            chk("a_hold_ready", 64'(in_ready_a), 64'd0);
            chk("a_hold_busy", 64'(busy_a), 64'd1);
        end
        in_valid_a  = 1'b0;
        out_ready_a = 1'b1;
        tick();
        out_ready_a = 1'b0;
        chk("a_idle_ready", 64'(in_ready_a), 64'd1);
        chk("a_idle_valid", 64'(out_valid_a), 64'd0);
        chk("a_idle_bcd_held", 64'(out_bcd_a), exp_bcd);
    endtask

    task automatic conv_b(input logic [15:0] v, input int hold);
        logic [63:0] exp_bcd;
        int          k;
        exp_bcd = to_bcd(64'(v));
        chk("b_in_ready_before", 64'(in_ready_b), 64'd1);
        in_bin_b   = v;
        in_valid_b = 1'b1;
        tick();
        in_valid_b = 1'b0;
        k = 0;
        while (!out_valid_b && k < 200) begin
            tick();
            k++;
        end
        chk("b_latency", 64'(k), 64'd16);
        chk("b_bcd", 64'(out_bcd_b), exp_bcd);
`ifdef DDA_DIGIT_COUNT_EN
        chk("b_ndig", 64'(out_ndig_b), 64'(num_digits(64'(v))));
`endif
        repeat (hold) tick();
        chk("b_hold_bcd", 64'(out_bcd_b), exp_bcd);
        out_ready_b = 1'b1;
        tick();
        out_ready_b = 1'b0;
        chk("b_idle_ready", 64'(in_ready_b), 64'd1);
    endtask

    initial begin
        rst_n       = 1'b0;
        in_valid_a  = 1'b0;
        in_bin_a    = '0;
        out_ready_a = 1'b0;
        in_valid_b  = 1'b0;
        in_bin_b    = '0;
        out_ready_b = 1'b0;

        // Reset state
        repeat (3) tick();
        chk("rst_in_ready", 64'(in_ready_a), 64'd1);
        chk("rst_out_valid", 64'(out_valid_a), 64'd0);
        chk("rst_out_bcd", 64'(out_bcd_a), 64'd0);
        chk("rst_busy", 64'(busy_a), 64'd0);
`ifdef DDA_DIGIT_COUNT_EN
        chk("rst_ndig", 64'(out_ndig_a), 64'd0);
`endif
        rst_n = 1'b1;
        tick();

        // Full-scale, then directed values
        conv_a(8'd255, 0, 1'b0);
        conv_a(8'd0,   0, 1'b0);
        conv_a(8'd9,   1, 1'b0);
        conv_a(8'd10,  0, 1'b0);
        conv_a(8'd100, 2, 1'b0);
        conv_a(8'd173, 0, 1'b0);

        // Backpressure with a competing request held high
        conv_a(8'd200, 5, 1'b1);
        tick();
        chk("bp_no_accept", 64'(in_ready_a), 64'd1);

        // Competing request during SHIFT of 42
        conv_a(8'd42, 0, 1'b1);

        // Reset at iteration 4
        in_bin_a   = 8'd99;
        in_valid_a = 1'b1;
        tick();
        in_valid_a = 1'b0;
        repeat (4) tick();
        rst_n = 1'b0;
        #1;
        chk("mid_rst_in_ready", 64'(in_ready_a), 64'd1);
        chk("mid_rst_valid", 64'(out_valid_a), 64'd0);
        chk("mid_rst_bcd", 64'(out_bcd_a), 64'd0);
        chk("mid_rst_busy", 64'(busy_a), 64'd0);
        tick();
        chk("mid_rst_still_idle", 64'(busy_a), 64'd0);
        rst_n = 1'b1;
        tick();
        conv_a(8'd42, 0, 1'b0);

        // Exhaustive sweep with random consumer stalls
        for (int v = 0; v < 256; v++) begin
            conv_a(8'(v), int'($urandom_range(0, 3)), 1'b0);
        end

        // Wide build: full scale plus random operands
        conv_b(16'd65535, 2);
        conv_b(16'd0, 0);
        for (int i = 0; i < 20; i++) begin
            conv_b(16'($urandom), int'($urandom_range(0, 3)));
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
